output_tile_writer: RTL and testbench
=====================================

Name: output_tile_writer

Overview:
- Successor to the single-row output writer. Drains a full or partial output tile (up to N rows of N values) from the processing array to memory.
- Each row goes to its own strided address, so results can be written into a larger matrix in memory.
- A ROW_FIFO_DEPTH-row buffer lets the processor keep streaming rows while earlier rows are still being written.
- Sits between the controller (instruction and completion handshakes), the processor output stream and the memory write port.

Parameters:
- DATA_W, 18, width of one output value.
- N, 4, array width; values per row; maximum rows per tile.
- PAR, 2, values written per memory beat; must divide N (elaboration assertion).
- ADDR_W, 16, memory word-address width.
- ROW_FIFO_DEPTH, 2, rows buffered; must be at least 1.
- CNT_W, $clog2(N+1), width of the row-count field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block accepts instruction
- instr_base_addr  in  ADDR_W  address of row 0, value 0
- instr_row_stride  in  ADDR_W  address step between consecutive rows
- instr_row_count  in  CNT_W  rows to write, 0..N
- instr_by_row  in  1  1 = processor emits rows, 0 = columns
- done_valid  out  1  tile fully written
- done_ready  in  1  controller acknowledges completion
- wr_valid  out  1  memory write beat valid
- wr_ready  in  1  memory accepts beat
- wr_addr  out  ADDR_W  beat address
- wr_data  out  PAR x DATA_W  beat data; element i goes to wr_addr+i
- proc_valid  in  1  processor row valid
- proc_ready  out  1  block accepts row
- proc_by_row  out  1  latched instr_by_row
- proc_data  in  N x DATA_W  one row/column of results

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset values:
  - state IDLE; FIFO empty; all counters 0.
  - instr_ready=1; done_valid=0; wr_valid=0; proc_ready=0.
  - wr_addr=0; proc_by_row=0.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch all instruction fields; row_addr=instr_base_addr.
  - Next state is RUN, or DONE if instr_row_count==0.
- RUN:
  - instr_ready=0.
  - proc_ready = (FIFO not full) && (rows_accepted < row_count).
  - Each proc handshake pushes proc_data and increments rows_accepted.
- Memory side, FIFO is registered:
  - A row accepted at edge t makes wr_valid=1 from cycle t+1.
  - wr_valid = FIFO not empty.
  - wr_data[i] = head[beat*PAR+i]; wr_addr = row_addr + beat*PAR, modulo 2^ADDR_W (wraps silently).
  - beat counts 0..N/PAR-1. On the final beat handshake: pop the FIFO, beat=0, row_addr+=row_stride (no multiplier), rows_written++.
- Transition to DONE: in RUN, on the handshake that makes rows_written==row_count.
- DONE:
  - done_valid=1; proc_ready=0; wr_valid=0; instr_ready=0.
  - On done_ready, return to IDLE.
  - done_valid holds indefinitely until acknowledged.
- wr_addr and wr_data are stable while wr_valid&&!wr_ready.
- proc_ready never depends on wr_ready in the same cycle (no combinational path). A full FIFO blocks a push even if a pop occurs that cycle.
- A push and a pop in the same cycle on a non-full FIFO both take effect.
- Extra proc_valid beyond row_count is ignored (proc_ready=0).
- proc_by_row is informational; no internal transpose.
- Reset mid-operation: FIFO flushed, buffered data discarded, FSM returns to IDLE, no done_valid is emitted.
- Throughput: 1 beat/cycle under continuous wr_ready. One row takes N/PAR cycles.

Decomposition:
- Package otw_pkg:
  - typedef otw_state_e {IDLE,RUN,DONE}.
  - typedef otw_instr_t {base_addr, row_stride, row_count, by_row}.
  - localparam BEATS_PER_ROW=N/PAR; function clog2-safe width helpers.
- Sub-module row_fifo:
  - Synchronous FIFO of N x DATA_W rows, depth ROW_FIFO_DEPTH.
  - Ports: push/pop/full/empty/head.
  - Reused by the input-side loaders.

Test Plan:
- N=4,PAR=2, base=0x10, stride=8, count=4, wr_ready=1:
  - Addresses 0x10,0x12,0x18,0x1A,0x20,0x22,0x28,0x2A with matching data.
  - done_valid one cycle after the last beat.
- wr_ready held 0 for 10 cycles with proc_valid=1:
  - Exactly ROW_FIFO_DEPTH=2 rows accepted; proc_ready=0 afterwards.
  - wr_addr/wr_data stable; no data loss when wr_ready returns.
- count=0: DONE is entered the cycle after acceptance; zero write beats; done_valid held until done_ready.
- base=0xFFFE, stride=1, count=2: addresses 0xFFFE,0x0000,0xFFFF,0x0001 (modulo wrap).
- count=2 while the processor offers 4 rows: only 2 handshakes; remaining rows are never acknowledged; done after 4 beats.
- Assert reset mid-tile after 1 row written:
  - All outputs at reset values the next cycle.
  - A new instruction is accepted and runs cleanly with no stale data.

Source files
------------

// File: rtl/output_tile_writer_pkg.sv
// Shared types and defaults for the output tile writer and its row buffer.
package otw_pkg;

    // Width helper that never returns 0, so a counter for a single value still gets one bit.
    function automatic int otw_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int OTW_DATA_W         = 18;
    localparam int OTW_N              = 4;
    localparam int OTW_PAR            = 2;
    localparam int OTW_ADDR_W         = 16;
    localparam int OTW_ROW_FIFO_DEPTH = 2;
    localparam int OTW_CNT_W          = $clog2(OTW_N + 1);
    localparam int BEATS_PER_ROW      = OTW_N / OTW_PAR;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } otw_state_e;

    // Instruction fields latched for the lifetime of one tile.
    typedef struct packed {
        logic [OTW_ADDR_W-1:0] base_addr;
        logic [OTW_ADDR_W-1:0] row_stride;
        logic [OTW_CNT_W-1:0]  row_count;
        logic                  by_row;
    } otw_instr_t;

endpackage

// File: rtl/output_tile_writer_row_fifo.sv
// Small synchronous FIFO of whole rows. The head is read straight from the
// storage registers so a row pushed at one edge is visible the next cycle.
module row_fifo
    import otw_pkg::*;
#(
    parameter int WIDTH = OTW_N * OTW_DATA_W,
    parameter int DEPTH = OTW_ROW_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = otw_width(DEPTH);
    localparam int CNT_W = otw_width(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Row storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; a reset flushes everything buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/output_tile_writer.sv
// Drains an output tile row by row from the processing array into memory,
// one strided address per row, buffering rows so the array can keep streaming.
module output_tile_writer
    import otw_pkg::*;
#(
    parameter int DATA_W         = OTW_DATA_W,
    parameter int N              = OTW_N,
    parameter int PAR            = OTW_PAR,
    parameter int ADDR_W         = OTW_ADDR_W,
    parameter int ROW_FIFO_DEPTH = OTW_ROW_FIFO_DEPTH,
    parameter int CNT_W          = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [ADDR_W-1:0]     instr_base_addr,
    input  logic [ADDR_W-1:0]     instr_row_stride,
    input  logic [CNT_W-1:0]      instr_row_count,
    input  logic                  instr_by_row,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [PAR*DATA_W-1:0] wr_data,
    input  logic                  proc_valid,
    output logic                  proc_ready,
    output logic                  proc_by_row,
    input  logic [N*DATA_W-1:0]   proc_data
);

    localparam int BEATS  = N / PAR;
    localparam int BEAT_W = otw_width(BEATS);
    localparam int IDX_W  = otw_width(N);
    localparam int ROW_W  = N * DATA_W;

    // Parameter sanity: the latched instruction uses the package field widths.
    if (N % PAR != 0) begin : g_bad_par
        $error("output_tile_writer: PAR must divide N");
    end
    if (ROW_FIFO_DEPTH < 1) begin : g_bad_depth
        $error("output_tile_writer: ROW_FIFO_DEPTH must be at least 1");
    end
    if (ADDR_W != OTW_ADDR_W || CNT_W != OTW_CNT_W) begin : g_bad_width
        $error("output_tile_writer: ADDR_W/CNT_W must match otw_pkg widths");
    end

    otw_state_e       state_q, state_d;
    otw_instr_t       instr_q, instr_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  rows_accepted_q, rows_accepted_d;
    logic [CNT_W-1:0]  rows_written_q, rows_written_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ROW_W-1:0] fifo_head;
    logic [DATA_W-1:0] head_elem [N];

    row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (ROW_FIFO_DEPTH)
    ) u_row_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (proc_data),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    // Split the head row into its values so each write lane can pick one.
    for (genvar gi = 0; gi < N; gi++) begin : g_head_split
        assign head_elem[gi] = fifo_head[gi*DATA_W +: DATA_W];
    end

    // Lane gi of a beat carries value beat*PAR+gi of the head row.
    for (genvar gi = 0; gi < PAR; gi++) begin : g_lane
        logic [IDX_W-1:0] lane_idx;
        assign lane_idx = IDX_W'(int'(beat_q) * PAR + gi);
        assign wr_data[gi*DATA_W +: DATA_W] = head_elem[lane_idx];
    end

    // Address only moves on a handshake, so it holds steady during a stall; wraps modulo 2^ADDR_W.
    assign wr_addr     = row_addr_q + ADDR_W'(beat_q) * ADDR_W'(PAR);
    assign proc_by_row = instr_q.by_row;

    // Next-state and handshake decode for the tile sequencer.
    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        row_addr_d      = row_addr_q;
        beat_d          = beat_q;
        rows_accepted_d = rows_accepted_q;
        rows_written_d  = rows_written_q;
        instr_ready     = 1'b0;
        done_valid      = 1'b0;
        proc_ready      = 1'b0;
        wr_valid        = 1'b0;
        fifo_push       = 1'b0;
        fifo_pop        = 1'b0;

        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d.base_addr  = instr_base_addr;
                    instr_d.row_stride = instr_row_stride;
                    instr_d.row_count  = instr_row_count;
                    instr_d.by_row     = instr_by_row;
                    row_addr_d         = instr_base_addr;
                    beat_d             = '0;
                    rows_accepted_d    = '0;
                    rows_written_d     = '0;
                    state_d            = (instr_row_count == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                // Acceptance depends only on registered state, never on wr_ready.
                proc_ready = !fifo_full && (rows_accepted_q < instr_q.row_count);
                fifo_push  = proc_valid && proc_ready;
                if (fifo_push) begin
                    rows_accepted_d = rows_accepted_q + CNT_W'(1);
                end

                wr_valid = !fifo_empty;
                if (wr_valid && wr_ready) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        fifo_pop       = 1'b1;
                        beat_d         = '0;
                        row_addr_d     = row_addr_q + instr_q.row_stride;
                        rows_written_d = rows_written_q + CNT_W'(1);
                        if (rows_written_q + CNT_W'(1) == instr_q.row_count) begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            instr_q         <= '0;
            row_addr_q      <= '0;
            beat_q          <= '0;
            rows_accepted_q <= '0;
            rows_written_q  <= '0;
        end else begin
            state_q         <= state_d;
            instr_q         <= instr_d;
            row_addr_q      <= row_addr_d;
            beat_q          <= beat_d;
            rows_accepted_q <= rows_accepted_d;
            rows_written_q  <= rows_written_d;
        end
    end

endmodule

// File: tb/tb_output_tile_writer.sv
// Directed-plus-random bench for output_tile_writer with a tile-level reference model.
module tb_output_tile_writer;

    localparam int DATA_W = 18;
    localparam int N      = 4;
    localparam int PAR    = 2;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int BEATS  = N / PAR;
    localparam int ROW_W  = N * DATA_W;
    localparam int BEAT_DW = PAR * DATA_W;

    logic                clk = 1'b0;
    logic                reset;
    logic                instr_valid;
    logic                instr_ready;
    logic [ADDR_W-1:0]   instr_base_addr;
    logic [ADDR_W-1:0]   instr_row_stride;
    logic [CNT_W-1:0]    instr_row_count;
    logic                instr_by_row;
    logic                done_valid;
    logic                done_ready;
    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [BEAT_DW-1:0]  wr_data;
    logic                proc_valid;
    logic                proc_ready;
    logic                proc_by_row;
    logic [ROW_W-1:0]    proc_data;

    output_tile_writer #(
        .DATA_W         (DATA_W),
        .N              (N),
        .PAR            (PAR),
        .ADDR_W         (ADDR_W),
        .ROW_FIFO_DEPTH (DEPTH),
        .CNT_W          (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_base_addr  (instr_base_addr),
        .instr_row_stride (instr_row_stride),
        .instr_row_count  (instr_row_count),
        .instr_by_row     (instr_by_row),
        .done_valid       (done_valid),
        .done_ready       (done_ready),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .proc_valid       (proc_valid),
        .proc_ready       (proc_ready),
        .proc_by_row      (proc_by_row),
        .proc_data        (proc_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdy_mode = 0;          // 0: always ready, 1: random, 2: driven by the sequence
    int accept_cyc = -1;
    int last_beat_cyc = -1;
    int done_cyc = -1;
    bit instr_fire;
    bit stall_prev = 1'b0;
    logic [ADDR_W-1:0]  stall_addr;
    logic [BEAT_DW-1:0] stall_data;

    logic [ROW_W-1:0]   offer[$];
    logic [ROW_W-1:0]   rows_ref[$];
    logic [ROW_W-1:0]   accepted[$];
    logic [ADDR_W-1:0]  got_addr[$];
    logic [BEAT_DW-1:0] got_data[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: beat k of a tile is row k/BEATS, lanes starting at (k%BEATS)*PAR.
    function automatic logic [ADDR_W-1:0] exp_addr(input int base, input int stride, input int k);
        int r = k / BEATS;
        int b = k % BEATS;
        return ADDR_W'(base + r * stride + b * PAR);
    endfunction

    function automatic logic [BEAT_DW-1:0] exp_data(input int k);
        logic [ROW_W-1:0]   row = rows_ref[k / BEATS];
        logic [BEAT_DW-1:0] d;
        int b = k % BEATS;
        for (int i = 0; i < PAR; i++) begin
            d[i*DATA_W +: DATA_W] = row[(b * PAR + i) * DATA_W +: DATA_W];
        end
        return d;
    endfunction

    // One clock: sample handshakes at the falling edge, update drivers just after the rising edge.
    task automatic step();
        bit fire_p, fire_w;
        @(negedge clk);
        fire_p     = proc_valid && proc_ready;
        fire_w     = wr_valid && wr_ready;
        instr_fire = instr_valid && instr_ready;
        if (stall_prev) begin
            chk("stall_wr_valid", wr_valid, 1'b1);
            chk("stall_wr_addr", wr_addr, stall_addr);
            chk("stall_wr_data", wr_data, stall_data);
        end
        stall_prev = wr_valid && !wr_ready;
        stall_addr = wr_addr;
        stall_data = wr_data;
        if (fire_p) accepted.push_back(proc_data);
        if (fire_w) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            last_beat_cyc = cyc;
        end
        if (instr_fire) accept_cyc = cyc;
        if (done_valid && done_cyc < 0) done_cyc = cyc;
        @(posedge clk);
        #1;
        if (fire_p && offer.size() > 0) void'(offer.pop_front());
        proc_valid = (offer.size() > 0);
        if (offer.size() > 0) proc_data = offer[0];
        if (rdy_mode == 0) wr_ready = 1'b1;
        else if (rdy_mode == 1) wr_ready = 1'($urandom_range(0, 1));
        cyc++;
    endtask

    task automatic make_rows(input int n);
        logic [ROW_W-1:0] row;
        offer.delete();
        rows_ref.delete();
        for (int r = 0; r < n; r++) begin
            for (int e = 0; e < N; e++) row[e*DATA_W +: DATA_W] = DATA_W'($urandom);
            offer.push_back(row);
            rows_ref.push_back(row);
        end
        proc_valid = (n > 0);
        if (n > 0) proc_data = offer[0];
    endtask

    task automatic start_instr(input int base, input int stride, input int count, input bit by_row);
        int t = 0;
        accepted.delete();
        got_addr.delete();
        got_data.delete();
        accept_cyc = -1;
        last_beat_cyc = -1;
        done_cyc = -1;
        done_ready = 1'b0;
        instr_base_addr  = ADDR_W'(base);
        instr_row_stride = ADDR_W'(stride);
        instr_row_count  = CNT_W'(count);
        instr_by_row     = by_row;
        instr_valid      = 1'b1;
        instr_fire       = 1'b0;
        while (!instr_fire && t < 20) begin
            step();
            t++;
        end
        instr_valid = 1'b0;
        if (!instr_fire) chk("instr_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic finish_tile(input int base, input int stride, input int count);
        int t = 0;
        int nb;
        while (done_cyc < 0 && t < 400) begin
            step();
            t++;
        end
        if (done_cyc < 0) chk("done_timeout", 1'b0, 1'b1);
        chk("rows_accepted", accepted.size(), count);
        chk("beat_count", got_addr.size(), count * BEATS);
        nb = (got_addr.size() < count * BEATS) ? got_addr.size() : count * BEATS;
        for (int k = 0; k < nb; k++) begin
            chk("beat_addr", got_addr[k], exp_addr(base, stride, k));
            chk("beat_data", got_data[k], exp_data(k));
        end
        for (int r = 0; r < accepted.size() && r < count; r++) chk("accepted_row", accepted[r], rows_ref[r]);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_hold", done_valid, 1'b1);
            chk("done_wr_valid", wr_valid, 1'b0);
            chk("done_proc_ready", proc_ready, 1'b0);
            chk("done_instr_ready", instr_ready, 1'b0);
        end
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk("done_release", done_valid, 1'b0);
        chk("idle_instr_ready", instr_ready, 1'b1);
        chk("no_extra_rows", accepted.size(), count);
        offer.delete();
        proc_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_instr_ready"}, instr_ready, 1'b1);
        chk({tag, "_done_valid"}, done_valid, 1'b0);
        chk({tag, "_wr_valid"}, wr_valid, 1'b0);
        chk({tag, "_proc_ready"}, proc_ready, 1'b0);
        chk({tag, "_wr_addr"}, wr_addr, 16'h0);
        chk({tag, "_proc_by_row"}, proc_by_row, 1'b0);
    endtask

    initial begin
        int t;
        int base, stride, count;
        logic [ADDR_W-1:0] fixed_addr [8];
        reset = 1'b1;
        instr_valid = 1'b0;
        instr_base_addr = '0;
        instr_row_stride = '0;
        instr_row_count = '0;
        instr_by_row = 1'b0;
        done_ready = 1'b0;
        wr_ready = 1'b1;
        proc_valid = 1'b0;
        proc_data = '0;

        step();
        step();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Directed tile with continuous wr_ready.
        fixed_addr = '{16'h10, 16'h12, 16'h18, 16'h1A, 16'h20, 16'h22, 16'h28, 16'h2A};
        rdy_mode = 0;
        make_rows(4);
        start_instr(16'h10, 8, 4, 1'b1);
        chk("proc_by_row", proc_by_row, 1'b1);
        while (done_cyc < 0 && cyc < 2000) step();
        for (int k = 0; k < 8 && k < got_addr.size(); k++) chk("fixed_addr", got_addr[k], fixed_addr[k]);
        chk("done_latency", done_cyc, last_beat_cyc + 1);
        finish_tile(16'h10, 8, 4);
        $display("tile base=0010 stride=8 count=4 beats=%0d", got_addr.size());

        // Memory stalled for 10 cycles while the processor keeps offering rows.
        rdy_mode = 2;
        wr_ready = 1'b0;
        make_rows(4);
        start_instr(16'h100, 16'h20, 4, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("stall_rows_accepted", accepted.size(), DEPTH);
        chk("stall_proc_ready", proc_ready, 1'b0);
        chk("stall_no_beats", got_addr.size(), 0);
        rdy_mode = 1;
        finish_tile(16'h100, 16'h20, 4);
        $display("tile base=0100 stride=20 count=4 stalled beats=%0d", got_addr.size());

        // Zero-row instruction.
        rdy_mode = 0;
        make_rows(2);
        start_instr(16'h40, 4, 0, 1'b0);
        step();
        chk("zero_done_latency", done_cyc, accept_cyc + 1);
        finish_tile(16'h40, 4, 0);
        $display("tile count=0 beats=%0d", got_addr.size());

        // Address wrap.
        make_rows(2);
        start_instr(16'hFFFE, 1, 2, 1'b1);
        finish_tile(16'hFFFE, 1, 2);
        $display("tile base=FFFE stride=1 count=2 beats=%0d", got_addr.size());

        // Fewer rows requested than the processor offers.
        rdy_mode = 1;
        make_rows(4);
        start_instr(16'h2000, 16'h100, 2, 1'b0);
        finish_tile(16'h2000, 16'h100, 2);
        $display("tile count=2 offered=4 beats=%0d", got_addr.size());

        // Reset after the first row has been written.
        rdy_mode = 0;
        make_rows(4);
        start_instr(16'h300, 16'h10, 4, 1'b1);
        t = 0;
        while (got_addr.size() < BEATS && t < 200) begin
            step();
            t++;
        end
        chk("midreset_first_row", got_addr.size(), BEATS);
        reset = 1'b1;
        step();
        reset = 1'b0;
        stall_prev = 1'b0;
        offer.delete();
        proc_valid = 1'b0;
        check_reset_outputs("midreset");
        step();
        chk("midreset_no_done", done_valid, 1'b0);
        rdy_mode = 1;
        make_rows(3);
        start_instr(16'h500, 16'h7, 3, 1'b0);
        finish_tile(16'h500, 16'h7, 3);
        $display("tile after reset base=0500 count=3 beats=%0d", got_addr.size());

        // Random tiles.
        for (int it = 0; it < 4; it++) begin
            base   = int'($urandom_range(0, 16'hFFFF));
            stride = int'($urandom_range(0, 16'hFFFF));
            count  = int'($urandom_range(0, N));
            make_rows(count + int'($urandom_range(0, 2)));
            start_instr(base, stride, count, 1'($urandom_range(0, 1)));
            finish_tile(base, stride, count);
            $display("tile random base=%04h stride=%04h count=%0d beats=%0d", base[15:0], stride[15:0], count, got_addr.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
